fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3, meaning number of in-flight producer stages compared for forwarding (legal 1..4).
REQ-002 Parameter LD_LAT, default 1, meaning number of bubble cycles inserted on a load-use hazard (legal 1..3).
REQ-003 Parameter SW, default 2, meaning width of each select output (SHALL satisfy 2**SW > DEPTH).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
REQ-006 ins  in  32  instruction word; opcode=ins[31:26], rd=ins[25:21], src_a=ins[20:16], src_b=ins[15:11], imm=ins[15:0].
REQ-007 in_valid  in  1  ins is valid this cycle.
REQ-008 in_ready  out  1  instruction accepted this cycle when in_valid&in_ready; upstream SHALL hold ins stable while in_ready==0.
REQ-009 ex_valid, op_ex[5:0], imm_ex[15:0], imm_sel_ex, mem_en_ex, mem_rw_ex  out  EX-stage control for the accepted instruction.
REQ-010 sel_a[SW-1:0], sel_b[SW-1:0]  out  operand forwarding selects: 0=register file, k=result of stage k.
REQ-011 rw_wb[4:0], rw_wb_en  out  destination address and write enable of the instruction in stage DEPTH.

Function
REQ-012 Decode SHALL be: ld=010100, st=010101, jmp=011000, cond_j=0111xx; imm_sel when opcode[5:3]==001; mem_en for ld|st; mem_rw=opcode[0] for ld|st, else 0.
REQ-013 Register reads SHALL be: jmp and cond_j none; all others src_a and src_b. Writes SHALL be: st, jmp, cond_j none; all others rd.
REQ-014 Register 0 SHALL never be forwarded, never cause a stall, and never assert rw_wb_en.
REQ-015 The unit SHALL keep a DEPTH-entry chain {valid, dst, writes, is_ld}; stage 1 holds the instruction in EX; the chain shifts every cycle, and stage 1 loads the accepted instruction or a bubble (valid=0).
REQ-016 On acceptance, sel_a SHALL be registered as the smallest k in 1..DEPTH with stage k valid&writes&dst==src_a (src_a read, nonzero), else 0; sel_b likewise for src_b.
REQ-017 Select outputs and EX controls SHALL appear one cycle after acceptance, aligned with ex_valid=1.
REQ-018 Controller states SHALL be RUN and STALL with counter cnt.
REQ-019 In RUN, in_ready=1 unless a load-use hazard exists: stage 1 valid&is_ld&dst matches a nonzero read source of ins while in_valid==1.
REQ-020 On a hazard, the controller SHALL move to STALL with cnt=LD_LAT-1, hold in_ready=0, and insert a bubble (ex_valid=0, EX controls 0, sel 0).
REQ-021 In STALL, a bubble SHALL be inserted each cycle and cnt decremented; at cnt==0 the controller SHALL return to RUN, where the held instruction is re-evaluated and forwarded from stage LD_LAT+1 when DEPTH allows, else from the register file.
REQ-022 When in_valid==0 in RUN, a bubble SHALL be inserted and no stall occurs.
REQ-023 When src_a==src_b, both selects SHALL assert the same value; a hazard on either source SHALL stall.
REQ-024 rw_wb/rw_wb_en SHALL reflect stage DEPTH combinationally from registered state.

Reset
REQ-025 With reset==0 at an edge: state=RUN, cnt=0, all chain valid=0, ex_valid=0, op_ex=0, imm_ex=0, imm_sel_ex=mem_en_ex=mem_rw_ex=0, sel_a=sel_b=0, rw_wb=0, rw_wb_en=0.
REQ-026 Reset SHALL take effect mid-STALL; in_ready SHALL be 1 on the first cycle after reset is released.

Verification (DEPTH=3, LD_LAT=1 unless stated)
REQ-027 add r3<-r1,r2, then add r4<-r3,r3 back-to-back -> second instruction in EX with sel_a=1, sel_b=1.
REQ-028 Producer r5, two independent instructions, then consumer of r5 -> sel=3; with one more independent instruction -> sel=0.
REQ-029 ld r7, then add r8<-r7,r1 -> in_ready=0 for 1 cycle, one bubble (ex_valid=0), then add in EX with sel_a=2, sel_b=0.
REQ-030 Producers write r0, then consumer reads r0 -> sel 0, no stall; two producers of r6 at stages 1 and 2 -> sel=1.
REQ-031 With LD_LAT=2, a load-use hazard asserts in_ready=0 for 2 cycles; reset==0 during the first stall cycle -> all outputs at reset values next cycle and in_ready=1 after release.
REQ-032 st, then reader of st's rd field -> sel 0 (st writes nothing); rw_wb_en stays 0 when the st reaches stage 3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall controller
module fwd_hazard_unit #(
    parameter int DEPTH  = 3,
    parameter int LD_LAT = 1,
    parameter int SW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ins,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ex_valid,
    output logic [5:0]    op_ex,
    output logic [15:0]   imm_ex,
    output logic          imm_sel_ex,
    output logic          mem_en_ex,
    output logic          mem_rw_ex,
    output logic [SW-1:0] sel_a,
    output logic [SW-1:0] sel_b,
    output logic [4:0]    rw_wb,
    output logic          rw_wb_en
);
    typedef enum logic {RUN, STALL} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DEPTH-1:0]  v_q, wr_q, ld_q;
    logic [4:0]        dst_q [DEPTH];

    logic [5:0]    opcode;
    logic [4:0]    rd, src_a, src_b;
    logic          is_ld, is_st, reads, writes, rd_a, rd_b, haz, accept;
    logic [SW-1:0] fa, fb;

    assign opcode = ins[31:26];
    assign rd     = ins[25:21];
    assign src_a  = ins[20:16];
    assign src_b  = ins[15:11];

    // Decode, load-use hazard detection, forwarding selects and controller next state
    always_comb begin
        is_ld  = opcode == 6'b010100;
        is_st  = opcode == 6'b010101;
        reads  = !(opcode == 6'b011000 || opcode[5:2] == 4'b0111);
        writes = reads && !is_st && rd != 5'd0;
        rd_a   = reads && src_a != 5'd0;
        rd_b   = reads && src_b != 5'd0;
        haz    = state_q == RUN && in_valid && v_q[0] && ld_q[0] && wr_q[0] &&
                 ((rd_a && dst_q[0] == src_a) || (rd_b && dst_q[0] == src_b));
        in_ready = state_q == RUN && !haz;
        accept   = in_valid && in_ready;
        fa = '0;
        fb = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && wr_q[k] && rd_a && dst_q[k] == src_a) fa = SW'(k + 1);
            if (v_q[k] && wr_q[k] && rd_b && dst_q[k] == src_b) fb = SW'(k + 1);
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        if (haz) begin
            state_d = LD_LAT > 1 ? STALL : RUN;
            cnt_d   = 2'(LD_LAT - 1);
        end else if (state_q == STALL) begin
            cnt_d   = cnt_q - 2'd1;
            state_d = cnt_q == 2'd1 ? RUN : STALL;
        end
    end

    // Controller state, producer chain shift and registered EX-stage outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            v_q        <= '0;
            wr_q       <= '0;
            ld_q       <= '0;
            for (int k = 0; k < DEPTH; k++) dst_q[k] <= '0;
            ex_valid   <= 1'b0;
            op_ex      <= '0;
            imm_ex     <= '0;
            imm_sel_ex <= 1'b0;
            mem_en_ex  <= 1'b0;
            mem_rw_ex  <= 1'b0;
            sel_a      <= '0;
            sel_b      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int k = DEPTH - 1; k > 0; k--) begin
                v_q[k]   <= v_q[k-1];
                wr_q[k]  <= wr_q[k-1];
                ld_q[k]  <= ld_q[k-1];
                dst_q[k] <= dst_q[k-1];
            end
            v_q[0]     <= accept;
            wr_q[0]    <= accept && writes;
            ld_q[0]    <= accept && is_ld;
            dst_q[0]   <= accept ? rd : '0;
            ex_valid   <= accept;
            op_ex      <= accept ? opcode : '0;
            imm_ex     <= accept ? ins[15:0] : '0;
            imm_sel_ex <= accept && opcode[5:3] == 3'b001;
            mem_en_ex  <= accept && (is_ld || is_st);
            mem_rw_ex  <= accept && (is_ld || is_st) && opcode[0];
            sel_a      <= accept ? fa : '0;
            sel_b      <= accept ? fb : '0;
        end
    end

    assign rw_wb    = dst_q[DEPTH-1];
    assign rw_wb_en = v_q[DEPTH-1] && wr_q[DEPTH-1];
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for forwarding selects and load-use stalls
module tb_fwd_hazard_unit;
    localparam logic [5:0] ADD = 6'b000000, LD = 6'b010100, ST = 6'b010101;
    localparam logic [5:0] CJ = 6'b011101, ADDI = 6'b001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, ex_valid, imm_sel_ex, mem_en_ex, mem_rw_ex, rw_wb_en;
    logic [31:0] ins;
    logic [5:0]  op_ex;
    logic [15:0] imm_ex;
    logic [1:0]  sel_a, sel_b;
    logic [4:0]  rw_wb;

    logic        reset2, in_valid2, in_ready2, ex_valid2, imm_sel_ex2, mem_en_ex2, mem_rw_ex2, rw_wb_en2;
    logic [31:0] ins2;
    logic [5:0]  op_ex2;
    logic [15:0] imm_ex2;
    logic [1:0]  sel_a2, sel_b2;
    logic [4:0]  rw_wb2;

    fwd_hazard_unit #(.DEPTH(3), .LD_LAT(1), .SW(2)) u1 (
        .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .in_ready(in_ready),
        .ex_valid(ex_valid), .op_ex(op_ex), .imm_ex(imm_ex), .imm_sel_ex(imm_sel_ex),
        .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex), .sel_a(sel_a), .sel_b(sel_b),
        .rw_wb(rw_wb), .rw_wb_en(rw_wb_en)
    );

    fwd_hazard_unit #(.DEPTH(3), .LD_LAT(2), .SW(2)) u2 (
        .clk(clk), .reset(reset2), .ins(ins2), .in_valid(in_valid2), .in_ready(in_ready2),
        .ex_valid(ex_valid2), .op_ex(op_ex2), .imm_ex(imm_ex2), .imm_sel_ex(imm_sel_ex2),
        .mem_en_ex(mem_en_ex2), .mem_rw_ex(mem_rw_ex2), .sel_a(sel_a2), .sel_b(sel_b2),
        .rw_wb(rw_wb2), .rw_wb_en(rw_wb_en2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return {op, d, a, b, 11'd0};
    endfunction

    function automatic logic [31:0] exp_of(input logic [31:0] w, input logic [1:0] sa, input logic [1:0] sb);
        logic [5:0] op;
        logic       mem;
        op  = w[31:26];
        mem = op == LD || op == ST;
        return {3'b0, op, w[15:0], op[5:3] == 3'b001, mem, mem & op[0], sa, sb};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (ex_valid) begin
                if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else chk("ex", {3'b0, op_ex, imm_ex, imm_sel_ex, mem_en_ex, mem_rw_ex, sel_a, sel_b}, q.pop_front());
            end else begin
                chk("bubble_ctl", {3'b0, op_ex, imm_ex, imm_sel_ex, mem_en_ex, mem_rw_ex, sel_a, sel_b}, 32'd0);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [1:0] sa, input logic [1:0] sb, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        ins = w;
        in_valid = 1'b1;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (stalls > 0) chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
                q.push_back(exp_of(w, sa, sb));
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step2();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        int s;
        reset = 1'b0; reset2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; ins = '0; ins2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctl", {3'b0, op_ex, imm_ex, imm_sel_ex, mem_en_ex, mem_rw_ex, sel_a, sel_b}, 32'd0);
        chk("rst_wb", {26'd0, rw_wb_en, rw_wb}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst2_ex_valid", {31'd0, ex_valid2}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1; reset2 = 1'b1;

        send(mk(ADD, 5'd3, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd4, 5'd3, 5'd3), 2'd1, 2'd1, s);
        chk("b2b_stall", s, 0);
        idle(4);

        send(mk(ADD, 5'd5, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd9, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd10, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd11, 5'd5, 5'd1), 2'd3, 2'd0, s);
        idle(4);
        send(mk(ADD, 5'd5, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd9, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd10, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd12, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd11, 5'd5, 5'd1), 2'd0, 2'd0, s);
        idle(4);

        send(mk(LD, 5'd7, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd8, 5'd7, 5'd1), 2'd2, 2'd0, s);
        chk("ld_use_stall", s, 1);
        idle(4);

        send(mk(ADD, 5'd0, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(LD, 5'd0, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd12, 5'd0, 5'd0), 2'd0, 2'd0, s);
        chk("r0_stall", s, 0);
        idle(4);
        send(mk(ADD, 5'd6, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd6, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd13, 5'd6, 5'd2), 2'd1, 2'd0, s);
        idle(4);

        send(mk(ST, 5'd14, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd15, 5'd14, 5'd14), 2'd0, 2'd0, s);
        @(negedge clk);
        step2();
        chk("st_wb_en", {31'd0, rw_wb_en}, 32'd0);
        step2();
        chk("add_wb", {26'd0, rw_wb_en, rw_wb}, {26'd0, 1'b1, 5'd15});
        idle(4);

        send(mk(ADD, 5'd16, 5'd1, 5'd2), 2'd0, 2'd0, s);
        send(mk(CJ, 5'd16, 5'd16, 5'd16), 2'd0, 2'd0, s);
        send(mk(ADD, 5'd17, 5'd16, 5'd1), 2'd2, 2'd0, s);
        idle(4);
        send({ADDI, 5'd18, 5'd1, 16'h1234}, 2'd0, 2'd0, s);
        send(mk(ADD, 5'd19, 5'd18, 5'd18), 2'd1, 2'd1, s);
        idle(4);
        chk("sb_empty", q.size(), 0);

        ins2 = mk(LD, 5'd7, 5'd1, 5'd2);
        in_valid2 = 1'b1;
        @(negedge clk);
        chk("l2_ld_ready", {31'd0, in_ready2}, 32'd1);
        @(posedge clk);
        #1;
        ins2 = mk(ADD, 5'd8, 5'd7, 5'd1);
        @(negedge clk);
        chk("l2_stall1", {31'd0, in_ready2}, 32'd0);
        step2();
        chk("l2_stall2", {30'd0, in_ready2, ex_valid2}, 32'd0);
        step2();
        chk("l2_resume", {30'd0, in_ready2, ex_valid2}, 32'd2);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("l2_fwd", {28'd0, ex_valid2, sel_a2, 1'b0}, {28'd0, 1'b1, 2'd3, 1'b0});
        chk("l2_fwd_b", {30'd0, sel_b2}, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        ins2 = mk(LD, 5'd7, 5'd1, 5'd2);
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        ins2 = mk(ADD, 5'd8, 5'd7, 5'd1);
        @(negedge clk);
        chk("l2r_stall", {31'd0, in_ready2}, 32'd0);
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        @(posedge clk);
        #1;
        reset2 = 1'b1;
        @(negedge clk);
        chk("l2r_ctl", {3'b0, op_ex2, imm_ex2, imm_sel_ex2, mem_en_ex2, mem_rw_ex2, sel_a2, sel_b2}, 32'd0);
        chk("l2r_valid_wb", {25'd0, ex_valid2, rw_wb_en2, rw_wb2}, 32'd0);
        chk("l2r_ready", {31'd0, in_ready2}, 32'd1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("l2r_after", {29'd0, ex_valid2, sel_a2}, {29'd0, 1'b1, 2'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
